// File: rtl/serdes_lock_rst_seq_if.sv
// Bundle between the SERDES lock/reset sequencer and the logic around it.
//   pll_locked    : raw PLL LOCKED, asynchronous to the sequencer clock
//   restart       : 1-cycle synchronous request to re-run the whole sequence
//   pll_rst       : PLL reset
//   serdes_rst    : SERDES / bitslice reset
//   ready         : link clocking ready
//   state         : 0 PLL_RST, 1 WAIT_LOCK, 2 SERDES_RST, 3 RUN
//   lock_loss_cnt : saturating count of lock drops in SERDES_RST/RUN
//   timeout_err   : sticky, at least one WAIT_LOCK timeout since reset
// master = the sequencer, slave = the surrounding logic.
interface serdes_lock_rst_seq_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             restart;
  logic             pll_rst;
  logic             serdes_rst;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic             timeout_err;

  modport master (
    input  pll_locked, restart,
    output pll_rst, serdes_rst, ready, state, lock_loss_cnt, timeout_err
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, serdes_rst, ready, state, lock_loss_cnt, timeout_err
  );
endinterface

// File: rtl/serdes_lock_rst_seq.sv
// SERDES PLL lock qualification and reset sequencer. Runs on a free-running
// reference clock; holds the PLL in reset, waits for a stable synchronized
// lock, pulses the SERDES reset, then reports ready. Any lock loss, lock
// timeout or restart request sends it back to the PLL reset step.
// Ports:
//   clk : free-running reference clock
//   rst : synchronous active-high reset
//   bus : serdes_lock_rst_seq_if.master (see interface file for signals)
module serdes_lock_rst_seq #(
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 64,
  parameter int LOCK_TIMEOUT_CYC = 4096,
  parameter int SERDES_RST_CYC   = 8,
  parameter int CNT_W            = 8
) (
  input logic                   clk,
  input logic                   rst,
  serdes_lock_rst_seq_if.master bus
);

  localparam int TMR_MAX_A = (PLL_RST_CYC > SERDES_RST_CYC) ? PLL_RST_CYC : SERDES_RST_CYC;
  localparam int TMR_MAX   = (LOCK_TIMEOUT_CYC > TMR_MAX_A) ? LOCK_TIMEOUT_CYC : TMR_MAX_A;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int STB_W     = $clog2(LOCK_STABLE_CYC + 1);

  typedef enum logic [1:0] {
    S_PLL_RST    = 2'd0,
    S_WAIT_LOCK  = 2'd1,
    S_SERDES_RST = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  state_t                 state;
  state_t                 nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [TMR_W-1:0]       timer;
  logic [STB_W-1:0]       stable;
  logic                   enter;
  logic                   loss;
  logic                   tmo;
  logic                   pll_rst;
  logic                   serdes_rst;
  logic                   ready;
  logic [CNT_W-1:0]       lock_loss_cnt;
  logic                   timeout_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lock_s = sync[SYNC_STAGES-1];

  // Next-state decision. restart outranks lock loss, lock loss outranks the
  // SERDES_RST timer, and a qualified lock outranks the WAIT_LOCK timeout.
  always_comb begin
    nxt  = state;
    loss = 1'b0;
    tmo  = 1'b0;
    if (bus.restart) begin
      nxt = S_PLL_RST;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (timer == TMR_W'(PLL_RST_CYC - 1)) nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s && stable == STB_W'(LOCK_STABLE_CYC - 1)) begin
            nxt = S_SERDES_RST;
          end else if (timer == TMR_W'(LOCK_TIMEOUT_CYC - 1)) begin
            nxt = S_PLL_RST;
            tmo = 1'b1;
          end
        end
        S_SERDES_RST: begin
          if (!lock_s) begin
            nxt  = S_PLL_RST;
            loss = 1'b1;
          end else if (timer == TMR_W'(SERDES_RST_CYC - 1)) begin
            nxt = S_RUN;
          end
        end
        default: begin
          if (!lock_s) begin
            nxt  = S_PLL_RST;
            loss = 1'b1;
          end
        end
      endcase
    end
    // A restart in PLL_RST stays in the same state but must still re-arm the hold.
    enter = bus.restart || (nxt != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_PLL_RST;
      sync          <= '0;
      timer         <= '0;
      stable        <= '0;
      pll_rst       <= 1'b1;
      serdes_rst    <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_err   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.pll_locked};
      state  <= nxt;
      timer  <= enter ? '0 : timer + TMR_W'(1);
      stable <= (state == S_WAIT_LOCK && !enter && lock_s) ? stable + STB_W'(1) : '0;
      // Outputs follow the next state so they change on the transition edge.
      pll_rst    <= (nxt == S_PLL_RST);
      serdes_rst <= (nxt != S_RUN);
      ready      <= (nxt == S_RUN);
      if (loss) lock_loss_cnt <= sat_inc(lock_loss_cnt);
      if (tmo)  timeout_err   <= 1'b1;
    end
  end

  assign bus.pll_rst       = pll_rst;
  assign bus.serdes_rst    = serdes_rst;
  assign bus.ready         = ready;
  assign bus.state         = state;
  assign bus.lock_loss_cnt = lock_loss_cnt;
  assign bus.timeout_err   = timeout_err;

endmodule

// File: tb/tb_serdes_lock_rst_seq.sv
// Directed bench for serdes_lock_rst_seq: one instance with default timing,
// one with short timing and a 2-bit lock-loss counter.
module tb_serdes_lock_rst_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   n;
  int   saw2;

  always #5 clk = ~clk;

  serdes_lock_rst_seq_if #(.CNT_W(8)) b1 ();
  serdes_lock_rst_seq_if #(.CNT_W(2)) b2 ();

  serdes_lock_rst_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.master)
  );

  serdes_lock_rst_seq #(
    .PLL_RST_CYC      (2),
    .LOCK_STABLE_CYC  (3),
    .LOCK_TIMEOUT_CYC (20),
    .SERDES_RST_CYC   (2),
    .CNT_W            (2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps while PLL reset of the default instance is high; n = steps taken.
  task automatic cnt_pll_high(input int budget, output int cnt);
    cnt = 0;
    while (b1.pll_rst === 1'b1 && cnt < budget) begin
      step();
      cnt++;
    end
  endtask

  task automatic cnt_until_state(input int sel, input logic [1:0] s, input int budget,
                                 output int cnt);
    cnt = 0;
    while (((sel == 0) ? b1.state : b2.state) !== s && cnt < budget) begin
      step();
      cnt++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, b1.state, 0);
    chk({tag, "_pll_rst"}, b1.pll_rst, 1);
    chk({tag, "_serdes_rst"}, b1.serdes_rst, 1);
    chk({tag, "_ready"}, b1.ready, 0);
    chk({tag, "_cnt"}, b1.lock_loss_cnt, 0);
    chk({tag, "_terr"}, b1.timeout_err, 0);
  endtask

  initial begin
    b1.pll_locked = 1'b1;
    b1.restart    = 1'b0;
    b2.pll_locked = 1'b0;
    b2.restart    = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk_reset_vals("rst");

    // 1: lock tied high. Sync latency is hidden inside the 16-cycle PLL reset,
    // so WAIT_LOCK lasts exactly 64 cycles and SERDES_RST 8.
    rst = 1'b0;
    cnt_pll_high(100, n);
    chk("t1_pll_rst_len", n, 16);
    chk("t1_state_wait", b1.state, 1);
    chk("t1_serdes_held", b1.serdes_rst, 1);
    cnt_until_state(0, 2'd3, 200, n);
    chk("t1_to_run", n, 72);
    chk("t1_serdes_rst", b1.serdes_rst, 0);
    chk("t1_ready", b1.ready, 1);
    chk("t1_pll_rst", b1.pll_rst, 0);

    // 3: drop lock for 5 cycles in RUN; seen after 2 sync flops + 1 FSM edge.
    b1.pll_locked = 1'b0;
    cnt_pll_high(0, n);
    n = 0;
    while (b1.pll_rst !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("t3_drop_latency", n, 3);
    chk("t3_ready", b1.ready, 0);
    chk("t3_state", b1.state, 0);
    chk("t3_cnt", b1.lock_loss_cnt, 1);
    repeat (2) step();
    b1.pll_locked = 1'b1;
    cnt_until_state(0, 2'd3, 300, n);
    chk("t3_resequence", n < 300, 1);
    chk("t3_ready_again", b1.ready, 1);
    chk("t3_cnt_hold", b1.lock_loss_cnt, 1);

    // 6a: restart coincides with the cycle the FSM first sees lock low.
    b1.pll_locked = 1'b0;
    repeat (2) step();
    b1.restart = 1'b1;
    step();
    b1.restart = 1'b0;
    chk("t6_restart_state", b1.state, 0);
    chk("t6_restart_cnt", b1.lock_loss_cnt, 1);
    // Restart inside PLL_RST re-arms the full hold.
    b1.pll_locked = 1'b1;
    repeat (4) step();
    b1.restart = 1'b1;
    step();
    b1.restart = 1'b0;
    cnt_pll_high(100, n);
    chk("t6_rearm_len", n, 16);
    cnt_until_state(0, 2'd2, 200, n);
    chk("t6_to_serdes", n, 64);
    repeat (3) step();
    chk("t6_in_serdes", b1.state, 2);
    // 6b: reset mid-sequence.
    rst = 1'b1;
    step();
    chk_reset_vals("t6_rst");

    // 2: lock never rises.
    b1.pll_locked = 1'b0;
    rst = 1'b0;
    cnt_pll_high(100, n);
    chk("t2_pll_rst_len", n, 16);
    chk("t2_terr_before", b1.timeout_err, 0);
    cnt_until_state(0, 2'd0, 5000, n);
    chk("t2_timeout_len", n, 4096);
    chk("t2_terr", b1.timeout_err, 1);
    chk("t2_pll_rst", b1.pll_rst, 1);
    cnt_pll_high(100, n);
    chk("t2_retry_len", n, 16);
    chk("t2_terr_sticky", b1.timeout_err, 1);
    chk("t2_state_wait", b1.state, 1);

    // 4: lock toggling every 30 cycles never qualifies.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_terr_cleared", b1.timeout_err, 0);
    cnt_pll_high(100, n);
    n    = 0;
    saw2 = 0;
    while (b1.state !== 2'd0 && n < 5000) begin
      if (n % 30 == 29) b1.pll_locked = ~b1.pll_locked;
      step();
      n++;
      if (b1.state === 2'd2) saw2 = 1;
    end
    chk("t4_no_serdes", saw2, 0);
    chk("t4_timeout_len", n, 4096);
    chk("t4_terr", b1.timeout_err, 1);

    // 5: 2-bit lock-loss counter saturates at 3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_cnt_reset", b2.lock_loss_cnt, 0);
    chk("t5_terr_reset", b2.timeout_err, 0);
    for (int i = 0; i < 5; i++) begin
      b2.pll_locked = 1'b1;
      cnt_until_state(1, 2'd3, 100, n);
      chk("t5_reach_run", n < 100, 1);
      b2.pll_locked = 1'b0;
      cnt_until_state(1, 2'd0, 20, n);
      chk("t5_loss_latency", n, 3);
      chk("t5_cnt", b2.lock_loss_cnt, (i < 3) ? i + 1 : 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
